escalonador_acoes: RTL and testbench

- Sequencer that drives the one-hot `estado` input of the Tamagotchi attribute controller.
- Latches user action requests (sleep, eat, teach) and arbitrates between them.
- Holds each granted activity for a timed duration, forces sleep on exhaustion, and locks into MORTO once the pet dies.
- Sits between the debounced button logic and the attribute controller.

---
 rtl/tamagotchi_pkg.sv | 36 +++
 rtl/escalonador_acoes_divisor_tick.sv | 28 ++
 rtl/escalonador_acoes.sv | 166 ++++++++++++++++
 tb/tb_escalonador_acoes.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tamagotchi_pkg.sv
// Shared Tamagotchi constants: one-hot estado encodings, attribute ceiling
// and the activity-sequencer state type.
package tamagotchi_pkg;

    typedef enum logic [2:0] {
        S_OCIOSO,
        S_DORMINDO,
        S_COMENDO,
        S_DANDO_AULA,
        S_MORTO,
        S_DESCANSO
    } estado_t;

    localparam logic [3:0] EST_OCIOSO     = 4'b0000;
    localparam logic [3:0] EST_DORMINDO   = 4'b0001;
    localparam logic [3:0] EST_COMENDO    = 4'b0010;
    localparam logic [3:0] EST_DANDO_AULA = 4'b0100;
    localparam logic [3:0] EST_MORTO      = 4'b1000;

    localparam logic [7:0] MAX_ATRIB = 8'd100;

    // DESCANSO is internal only and shows up as OCIOSO on the one-hot bus.
    function automatic logic [3:0] codifica_estado(input estado_t s);
        logic [3:0] e;
        e = EST_OCIOSO;
        case (s)
            S_DORMINDO:   e = EST_DORMINDO;
            S_COMENDO:    e = EST_COMENDO;
            S_DANDO_AULA: e = EST_DANDO_AULA;
            S_MORTO:      e = EST_MORTO;
            default:      e = EST_OCIOSO;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/escalonador_acoes_divisor_tick.sv
// Free-running prescaler: counts 0..TICK_DIV-1 and flags the last count
// with a one-cycle tick.
module divisor_tick #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned W = $clog2(TICK_DIV);
    localparam logic [W-1:0] ULTIMO = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (cnt_reg == ULTIMO) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

    assign tick = (cnt_reg == ULTIMO);

endmodule

// File: rtl/escalonador_acoes.sv
// Activity sequencer for the Tamagotchi attribute controller: latches user
// requests, arbitrates, times activities. Optional DESCANSO: ESCALONADOR_COOLDOWN_EN.
module escalonador_acoes #(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned DUR_SONO    = 8,
    parameter int unsigned DUR_COMIDA  = 3,
    parameter int unsigned DUR_AULA    = 5,
    parameter logic [7:0]  LIMIAR_SONO = 8'd20,
    parameter logic [7:0]  MAX_ATRIB   = tamagotchi_pkg::MAX_ATRIB
`ifdef ESCALONADOR_COOLDOWN_EN
    ,
    parameter int unsigned COOLDOWN    = 2
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_dormir,
    input  logic       req_comer,
    input  logic       req_aula,
    input  logic       cancelar,
    input  logic [7:0] fome,
    input  logic [7:0] sono,
    input  logic [7:0] felicidade,
    input  logic       morreu,
    output logic [3:0] estado,
    output logic       ocupado,
    output logic [7:0] restante,
    output logic [2:0] pendentes
);

    import tamagotchi_pkg::*;

    localparam logic [7:0] DUR_SONO_B   = 8'(DUR_SONO);
    localparam logic [7:0] DUR_COMIDA_B = 8'(DUR_COMIDA);
    localparam logic [7:0] DUR_AULA_B   = 8'(DUR_AULA);
`ifdef ESCALONADOR_COOLDOWN_EN
    localparam logic [7:0] COOLDOWN_B   = 8'(COOLDOWN);
`endif

    estado_t    state_reg, state_next;
    logic [7:0] restante_reg, restante_next;
    logic [2:0] pend_reg, pend_next;
    logic [2:0] req;
    logic [2:0] limpa;
    logic       aceita;
    logic [7:0] alvo;
    logic       tick;

    divisor_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_divisor_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign req = {req_aula, req_comer, req_dormir};

    // Attribute each running activity is trying to fill up.
    always_comb begin
        alvo = 8'd0;
        case (state_reg)
            S_DORMINDO:   alvo = sono;
            S_COMENDO:    alvo = fome;
            S_DANDO_AULA: alvo = felicidade;
            default:      alvo = 8'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_OCIOSO;
            restante_reg <= 8'd0;
            pend_reg     <= 3'b000;
        end else begin
            state_reg    <= state_next;
            restante_reg <= restante_next;
            pend_reg     <= pend_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        restante_next = restante_reg;
        limpa         = 3'b000;
        aceita        = 1'b1;
        case (state_reg)
            S_OCIOSO: begin
                // A chosen request whose attribute is already full is
                // consumed without a grant; arbitration retries next cycle.
                if (sono <= LIMIAR_SONO) begin
                    state_next    = S_DORMINDO;
                    restante_next = DUR_SONO_B;
                    limpa         = 3'b001;
                end else if (pend_reg[1]) begin
                    limpa = 3'b010;
                    if (fome < MAX_ATRIB) begin
                        state_next    = S_COMENDO;
                        restante_next = DUR_COMIDA_B;
                    end
                end else if (pend_reg[0]) begin
                    limpa = 3'b001;
                    if (sono < MAX_ATRIB) begin
                        state_next    = S_DORMINDO;
                        restante_next = DUR_SONO_B;
                    end
                end else if (pend_reg[2]) begin
                    limpa = 3'b100;
                    if (felicidade < MAX_ATRIB) begin
                        state_next    = S_DANDO_AULA;
                        restante_next = DUR_AULA_B;
                    end
                end
            end
            S_DORMINDO, S_COMENDO, S_DANDO_AULA: begin
                if (cancelar || (alvo >= MAX_ATRIB) || (tick && restante_reg == 8'd1)) begin
`ifdef ESCALONADOR_COOLDOWN_EN
                    state_next    = S_DESCANSO;
                    restante_next = COOLDOWN_B;
`else
                    state_next    = S_OCIOSO;
                    restante_next = 8'd0;
`endif
                end else if (tick) begin
                    restante_next = restante_reg - 8'd1;
                end
            end
`ifdef ESCALONADOR_COOLDOWN_EN
            S_DESCANSO: begin
                aceita = 1'b0;
                if (restante_reg == 8'd0 || (tick && restante_reg == 8'd1)) begin
                    state_next    = S_OCIOSO;
                    restante_next = 8'd0;
                end else if (tick) begin
                    restante_next = restante_reg - 8'd1;
                end
            end
`endif
            S_MORTO: begin
                restante_next = 8'd0;
                limpa         = 3'b111;
                aceita        = 1'b0;
            end
            default: begin
                state_next    = S_OCIOSO;
                restante_next = 8'd0;
            end
        endcase

        // A fresh pulse re-latches even a bit being granted this cycle.
        pend_next = (pend_reg & ~limpa) | (aceita ? req : 3'b000);

        if (morreu) begin
            state_next    = S_MORTO;
            restante_next = 8'd0;
            pend_next     = 3'b000;
        end
    end

    assign estado    = codifica_estado(state_reg);
    assign ocupado   = (state_reg == S_DORMINDO) || (state_reg == S_COMENDO) ||
                       (state_reg == S_DANDO_AULA) || (state_reg == S_DESCANSO);
    assign restante  = restante_reg;
    assign pendentes = pend_reg;

endmodule

// File: tb/tb_escalonador_acoes.sv
// Bench for escalonador_acoes: directed literal checks plus randomized
// stimulus compared every cycle against an activity-level model.
module tb_escalonador_acoes;

    localparam int TICK_DIV = 4;
    localparam int LIMIAR   = 20;
    localparam int MAXA     = 100;
    localparam int COOLDOWN = 2;

    localparam int IDLE = 0, SLEEP = 1, EAT = 2, TEACH = 3, DEAD = 4, REST = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_dormir = 1'b0, req_comer = 1'b0, req_aula = 1'b0;
    logic       cancelar = 1'b0, morreu = 1'b0;
    logic [7:0] fome = 8'd50, sono = 8'd60, felicidade = 8'd60;
    logic [3:0] estado;
    logic       ocupado;
    logic [7:0] restante;
    logic [2:0] pendentes;

    int tests = 0;
    int fails = 0;

    escalonador_acoes #(
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_dormir (req_dormir),
        .req_comer  (req_comer),
        .req_aula   (req_aula),
        .cancelar   (cancelar),
        .fome       (fome),
        .sono       (sono),
        .felicidade (felicidade),
        .morreu     (morreu),
        .estado     (estado),
        .ocupado    (ocupado),
        .restante   (restante),
        .pendentes  (pendentes)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_act   = IDLE;
    int         m_left  = 0;
    logic [2:0] m_pend  = 3'b000;
    int         m_presc = 0;
    int         grant_order[3] = '{1, 0, 2};   // pending-bit indices: comer, dormir, aula

    function automatic int attr_of(input int a);
        case (a)
            SLEEP:   return int'(sono);
            EAT:     return int'(fome);
            TEACH:   return int'(felicidade);
            default: return 0;
        endcase
    endfunction

    function automatic int dur_of(input int a);
        case (a)
            SLEEP:   return 8;
            EAT:     return 3;
            TEACH:   return 5;
            default: return 0;
        endcase
    endfunction

    function automatic int est_of(input int a);
        case (a)
            SLEEP:   return 1;
            EAT:     return 2;
            TEACH:   return 4;
            DEAD:    return 8;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_act = IDLE; m_left = 0; m_pend = 3'b000; m_presc = 0;
    endtask

    task automatic model_step();
        bit         t;
        bit         was_rest;
        bit         found;
        logic [2:0] r;
        t        = (m_presc == TICK_DIV - 1);
        m_presc  = (m_presc + 1) % TICK_DIV;
        r        = {req_aula, req_comer, req_dormir};
        was_rest = (m_act == REST);
        if (m_act == DEAD || morreu) begin
            m_act = DEAD; m_left = 0; m_pend = 3'b000;
        end else begin
            if (m_act == IDLE) begin
                if (int'(sono) <= LIMIAR) begin
                    m_act = SLEEP; m_left = dur_of(SLEEP); m_pend[0] = 1'b0;
                end else begin
                    found = 0;
                    for (int i = 0; i < 3; i++) begin
                        if (!found && m_pend[grant_order[i]]) begin
                            found = 1;
                            m_pend[grant_order[i]] = 1'b0;
                            if (attr_of(grant_order[i] + 1) < MAXA) begin
                                m_act  = grant_order[i] + 1;
                                m_left = dur_of(m_act);
                            end
                        end
                    end
                end
            end else if (m_act == REST) begin
                if (m_left == 0 || (t && m_left == 1)) begin
                    m_act = IDLE; m_left = 0;
                end else if (t) begin
                    m_left--;
                end
            end else begin
                if (cancelar || attr_of(m_act) >= MAXA || (t && m_left == 1)) begin
`ifdef ESCALONADOR_COOLDOWN_EN
                    m_act = REST; m_left = COOLDOWN;
`else
                    m_act = IDLE; m_left = 0;
`endif
                end else if (t) begin
                    m_left--;
                end
            end
            if (!was_rest) m_pend = m_pend | r;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Compare process: every cycle, away from the active edge.
    initial forever begin
        @(negedge clk);
        chk("mdl_estado",    int'(estado),    est_of(m_act));
        chk("mdl_ocupado",   int'(ocupado),   int'(m_act == SLEEP || m_act == EAT || m_act == TEACH || m_act == REST));
        chk("mdl_restante",  int'(restante),  m_left);
        chk("mdl_pendentes", int'(pendentes), int'(m_pend));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_estado(input int v, input int budget, input string nm);
        int n = 0;
        while (int'(estado) != v && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, int'(estado), v);
    endtask

    task automatic wait_restante(input int v, input int budget, input string nm);
        int n = 0;
        while (int'(restante) != v && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, int'(restante), v);
    endtask

    function automatic logic [7:0] pick_attr();
        int tbl[10] = '{0, 19, 20, 21, 50, 60, 99, 100, 101, 255};
        if ($urandom_range(0, 1) == 0) return 8'(tbl[$urandom_range(0, 9)]);
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        int dead_cnt;
        int rst_hold;

        repeat (3) @(negedge clk);
        chk("rst_estado",    int'(estado),    0);
        chk("rst_ocupado",   int'(ocupado),   0);
        chk("rst_restante",  int'(restante),  0);
        chk("rst_pendentes", int'(pendentes), 0);
        rst_n = 1'b1;                                  // n0
        @(negedge clk);                                // n1
        req_comer = 1'b1;
        @(negedge clk);                                // n2
        req_comer = 1'b0;
        chk("single_latched", int'(pendentes), 3'b010);
        chk("single_still_idle", int'(estado), 0);
        @(negedge clk);                                // n3
        chk("single_estado", int'(estado), 4'b0010);
        chk("single_restante", int'(restante), 3);
        chk("single_pend_clear", int'(pendentes), 0);
        @(negedge clk);                                // n4: first tick
        chk("single_rest_after_tick", int'(restante), 2);
        repeat (7) @(negedge clk);                     // n11
        chk("single_last_cycle", int'(estado), 4'b0010);
        chk("single_rest_one", int'(restante), 1);
        @(negedge clk);                                // n12
        chk("single_exit_estado", int'(estado), 0);
        chk("single_exit_rest", int'(restante), 0);

`ifdef ESCALONADOR_COOLDOWN_EN
        chk("cd_ocupado_start", int'(ocupado), 1);
        chk("cd_restante_start", int'(restante), COOLDOWN);
        req_aula = 1'b1;
        @(negedge clk);                                // n13
        req_aula = 1'b0;
        repeat (6) @(negedge clk);                     // n19
        chk("cd_ocupado_end", int'(ocupado), 1);
        chk("cd_estado_hidden", int'(estado), 0);
        @(negedge clk);                                // n20
        chk("cd_released", int'(ocupado), 0);
        chk("cd_req_dropped", int'(pendentes), 0);
`else
        chk("idle_ocupado", int'(ocupado), 0);
        // Arbitration: all three in one cycle.
        req_aula = 1'b1; req_dormir = 1'b1; req_comer = 1'b1;
        @(negedge clk);
        req_aula = 1'b0; req_dormir = 1'b0; req_comer = 1'b0;
        chk("arb_latched", int'(pendentes), 3'b111);
        @(negedge clk);
        chk("arb_first_comer", int'(estado), 4'b0010);
        chk("arb_pend_101", int'(pendentes), 3'b101);
        wait_estado(0, 20, "arb_comer_exit");
        chk("arb_idle_pend", int'(pendentes), 3'b101);
        @(negedge clk);
        chk("arb_second_dormir", int'(estado), 4'b0001);
        chk("arb_pend_100", int'(pendentes), 3'b100);
        wait_estado(0, 40, "arb_dormir_exit");
        @(negedge clk);
        chk("arb_third_aula", int'(estado), 4'b0100);
        chk("arb_pend_000", int'(pendentes), 3'b000);
        chk("arb_aula_rest", int'(restante), 5);

        // Cancel at restante=4, with a request latched at the same edge.
        wait_restante(4, 10, "cancel_reach4");
        cancelar = 1'b1; req_comer = 1'b1;
        @(negedge clk);
        cancelar = 1'b0; req_comer = 1'b0;
        chk("cancel_estado", int'(estado), 0);
        chk("cancel_rest", int'(restante), 0);
        chk("cancel_pend", int'(pendentes), 3'b010);
        @(negedge clk);
        chk("cancel_then_comer", int'(estado), 4'b0010);

        // Death mid-COMENDO.
        morreu = 1'b1;
        @(negedge clk);
        morreu = 1'b0;
        chk("death_estado", int'(estado), 4'b1000);
        chk("death_ocupado", int'(ocupado), 0);
        chk("death_rest", int'(restante), 0);
        req_dormir = 1'b1; req_aula = 1'b1;
        @(negedge clk);
        req_dormir = 1'b0; req_aula = 1'b0;
        chk("death_no_latch", int'(pendentes), 0);
        repeat (5) @(negedge clk);
        chk("death_absorbing", int'(estado), 4'b1000);
        rst_n = 1'b0;
        #1;
        chk("death_async_rst", int'(estado), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Forced sleep, then saturated-sleep exit and drop.
        sono = 8'd20;
        @(negedge clk);
        chk("forced_sleep", int'(estado), 4'b0001);
        chk("forced_rest", int'(restante), 8);
        sono = 8'd100;
        @(negedge clk);
        chk("sat_exit", int'(estado), 0);
        req_dormir = 1'b1;
        @(negedge clk);
        req_dormir = 1'b0;
        chk("sat_latched", int'(pendentes), 3'b001);
        @(negedge clk);
        chk("sat_dropped_pend", int'(pendentes), 0);
        chk("sat_dropped_estado", int'(estado), 0);
        sono = 8'd60;
`endif

        // Randomized phase.
        dead_cnt = 0;
        rst_hold = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            req_dormir = ($urandom_range(0, 7) == 0);
            req_comer  = ($urandom_range(0, 7) == 0);
            req_aula   = ($urandom_range(0, 7) == 0);
            cancelar   = ($urandom_range(0, 31) == 0);
            morreu     = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 15) == 0) begin
                fome       = pick_attr();
                sono       = pick_attr();
                felicidade = pick_attr();
            end
            if (m_act == DEAD) dead_cnt++;
            else               dead_cnt = 0;
            if (rst_hold == 0 && (dead_cnt > 12 || $urandom_range(0, 999) == 0)) rst_hold = 2;
            if (rst_hold > 0) begin
                rst_n = 1'b0;
                rst_hold--;
            end else begin
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        req_dormir = 1'b0; req_comer = 1'b0; req_aula = 1'b0;
        cancelar = 1'b0; morreu = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
